// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC playback sequencer: state encoding and default widths.
package dac_seq_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_NP_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/dac_sequencer.sv
// PPS-triggered DAC waveform playback sequencer: after a PPS strobe and a
// programmable delay, plays npulse pulses of len samples, one every pri cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for arm; configuration validated and captured on arm
// ARMED | configuration held, waiting for the PPS strobe
// DELAY | counting down the PPS-to-first-sample delay
// PLAY  | tx_en high, stepping dac_addr through the pulse samples
// GAP   | between pulses, waiting for the next pulse start
// DONE  | one-cycle completion pulse, then back to IDLE
module dac_sequencer
    import dac_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int NP_W   = DEF_NP_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              arm,
    input  logic              abort,
    input  logic              pps,
    input  logic [CNT_W-1:0]  delay,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [CNT_W-1:0]  pri,
    input  logic [NP_W-1:0]   npulse,
    output logic [ADDR_W-1:0] dac_addr,
    output logic              tx_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // pri and len differ in width; compare them zero-extended to the wider one
    localparam int MW = (CNT_W > ADDR_W) ? CNT_W : ADDR_W;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;     // delay countdown, then cycles left until next pulse start
    logic [ADDR_W-1:0] samp_q;    // samples left in the current pulse after this one
    logic [NP_W-1:0]   pulse_q;   // pulses left after the current one
    logic [CNT_W-1:0]  delay_q;
    logic [CNT_W-1:0]  pri_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_q;
    logic              tx_en_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              cfg_bad;
    logic              start_pulse;
    logic              next_pulse;

    assign cfg_bad = (len == '0) || (npulse == '0) || (MW'(pri) < MW'(len));

    // Decide whether the coming edge begins a pulse (first or subsequent)
    always_comb begin
        start_pulse = 1'b0;
        next_pulse  = 1'b0;
        case (state_q)
            ARMED:   start_pulse = pps && (delay_q == '0);
            DELAY:   start_pulse = (cnt_q == '0);
            PLAY:    next_pulse  = (samp_q == '0) && (pulse_q != '0) && (cnt_q == '0);
            GAP:     next_pulse  = (cnt_q == '0);
            default: start_pulse = 1'b0;
        endcase
        if (next_pulse) begin
            start_pulse = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs; abort outranks everything but reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            samp_q  <= '0;
            pulse_q <= '0;
            delay_q <= '0;
            pri_q   <= '0;
            start_q <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            start_q <= start_addr;
                            len_q   <= len;
                            pri_q   <= pri;
                            delay_q <= delay;
                            pulse_q <= npulse - NP_W'(1);
                            busy_q  <= 1'b1;
                            state_q <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (pps) begin
                        // zero delay is handled by start_pulse going straight to PLAY
                        cnt_q   <= delay_q - CNT_W'(1);
                        state_q <= DELAY;
                    end
                end
                DELAY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                PLAY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (samp_q == '0) begin
                        tx_en_q <= 1'b0;
                        if (pulse_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= GAP;
                        end
                    end else begin
                        samp_q <= samp_q - ADDR_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    tx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            if (start_pulse) begin
                state_q <= PLAY;
                tx_en_q <= 1'b1;
                addr_q  <= start_q;
                samp_q  <= len_q - ADDR_W'(1);
                cnt_q   <= pri_q - CNT_W'(1);
            end
            if (next_pulse) begin
                pulse_q <= pulse_q - NP_W'(1);
            end
        end
    end

    assign dac_addr = addr_q;
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dac_sequencer.sv
// Self-checking bench for dac_sequencer: directed corner cases plus randomized
// sequences compared against a timeline model (pulse k starts delay+1+k*pri after pps).
module tb_dac_sequencer;

    logic        clk;
    logic        rstn;
    logic        arm;
    logic        abort;
    logic        pps;
    logic [31:0] delay;
    logic [13:0] start_addr;
    logic [13:0] len;
    logic [31:0] pri;
    logic [15:0] npulse;
    logic [13:0] dac_addr;
    logic        tx_en;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    dac_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .arm        (arm),
        .abort      (abort),
        .pps        (pps),
        .delay      (delay),
        .start_addr (start_addr),
        .len        (len),
        .pri        (pri),
        .npulse     (npulse),
        .dac_addr   (dac_addr),
        .tx_en      (tx_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_addr"}, 32'(dac_addr), 0);
        check_val({tag, "_tx"},   32'(tx_en), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_err"},  32'(err), 0);
    endtask

    // Arm, wait in ARMED with junk on the config inputs, fire pps, then compare
    // every cycle with the expected timeline. abort_m / rst_m (cycles after pps,
    // 0 = unused) cut the sequence short by abort or by reset.
    task automatic run_seq(input logic [13:0] st, input logic [13:0] ln, input int pr,
                           input int np, input int dl, input int abort_m, input int rst_m);
        int          done_m;
        int          rel;
        int          k;
        int          t;
        logic        exp_tx;
        logic [13:0] exp_addr;
        start_addr = st;
        len        = ln;
        pri        = 32'(pr);
        npulse     = 16'(np);
        delay      = 32'(dl);
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check_val("arm_busy", 32'(busy), 1);
        check_val("arm_err", 32'(err), 0);
        repeat ($urandom_range(0, 3)) begin
            start_addr = 14'($urandom);
            len        = 14'($urandom);
            pri        = $urandom;
            delay      = $urandom;
            npulse     = 16'($urandom);
            arm        = 1'($urandom_range(0, 1));
            tick();
        end
        arm = 1'b0;
        check_val("armed_tx", 32'(tx_en), 0);
        check_val("armed_busy", 32'(busy), 1);
        pps = 1'b1;
        tick();
        pps = 1'b0;
        done_m = dl + 1 + (np - 1) * pr + int'(ln);
        for (int m = 1; m <= done_m + 2; m++) begin
            rel      = m - (dl + 1);
            exp_tx   = 1'b0;
            exp_addr = st + ln - 14'd1;
            if (rel >= 0) begin
                k = rel / pr;
                t = rel % pr;
                if (k < np && t < int'(ln)) begin
                    exp_tx   = 1'b1;
                    exp_addr = st + 14'(t);
                end
                check_val("seq_addr", 32'(dac_addr), 32'(exp_addr));
            end
            check_val("seq_tx", 32'(tx_en), 32'(exp_tx));
            check_val("seq_done", 32'(done), 32'(m == done_m));
            check_val("seq_busy", 32'(busy), 32'(m <= done_m));
            if (m == abort_m) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_val("abort_tx", 32'(tx_en), 0);
                check_val("abort_busy", 32'(busy), 0);
                check_val("abort_done", 32'(done), 0);
                pps = 1'b1;
                tick();
                pps = 1'b0;
                repeat (done_m) begin
                    check_val("post_abort_tx", 32'(tx_en), 0);
                    check_val("post_abort_done", 32'(done), 0);
                    check_val("post_abort_busy", 32'(busy), 0);
                    tick();
                end
                return;
            end
            if (m == rst_m) begin
                #2 rstn = 1'b0;
                #1;
                check_all_zero("rst_mid");
                repeat (done_m) begin
                    tick();
                    check_val("rst_hold_done", 32'(done), 0);
                    check_val("rst_hold_tx", 32'(tx_en), 0);
                end
                rstn = 1'b1;
                tick();
                check_all_zero("rst_release");
                return;
            end
            tick();
        end
    endtask

    task automatic arm_bad(input logic [13:0] ln, input int pr, input int np, input string tag);
        start_addr = 14'd7;
        len        = ln;
        pri        = 32'(pr);
        npulse     = 16'(np);
        delay      = 32'd2;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check_val({tag, "_err"}, 32'(err), 1);
        check_val({tag, "_busy"}, 32'(busy), 0);
        tick();
        check_val({tag, "_busy_hold"}, 32'(busy), 0);
    endtask

    initial begin
        rstn       = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        pps        = 1'b0;
        delay      = '0;
        start_addr = '0;
        len        = '0;
        pri        = '0;
        npulse     = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();
        check_all_zero("idle");

        // pps in IDLE is ignored
        pps = 1'b1;
        tick();
        pps = 1'b0;
        check_val("idle_pps_busy", 32'(busy), 0);
        check_val("idle_pps_tx", 32'(tx_en), 0);

        // two pulses of 4 with a gap, delay 5: tx at P+6..9 and P+16..19, done at P+20
        run_seq(14'd100, 14'd4, 10, 2, 5, 0, 0);
        // back-to-back pulses with zero delay: 9 continuous samples from P+1
        run_seq(14'd40, 14'd3, 3, 3, 0, 0, 0);
        // address wrap-around at the top of the waveform memory
        run_seq(14'd16382, 14'd4, 4, 1, 2, 0, 0);
        run_seq(14'd16382, 14'd4, 6, 2, 1, 0, 0);

        // rejected configurations, then a valid arm clears err
        arm_bad(14'd4, 3, 2, "bad_pri");
        run_seq(14'd5, 14'd3, 3, 1, 1, 0, 0);
        arm_bad(14'd0, 5, 2, "bad_len");
        arm_bad(14'd2, 5, 0, "bad_np");

        // abort together with arm: abort wins, err left as it was
        start_addr = 14'd9;
        len        = 14'd2;
        pri        = 32'd4;
        npulse     = 16'd1;
        delay      = 32'd0;
        arm        = 1'b1;
        abort      = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check_val("abort_arm_busy", 32'(busy), 0);
        check_val("abort_arm_err", 32'(err), 1);
        run_seq(14'd9, 14'd2, 4, 1, 0, 0, 0);

        // abort together with pps in ARMED: back to IDLE, nothing played
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_val("ap_armed_busy", 32'(busy), 1);
        abort = 1'b1;
        pps   = 1'b1;
        tick();
        abort = 1'b0;
        pps   = 1'b0;
        repeat (4) begin
            check_val("ap_busy", 32'(busy), 0);
            check_val("ap_tx", 32'(tx_en), 0);
            tick();
        end

        // abort during the second pulse's PLAY, then a second pps
        run_seq(14'd100, 14'd4, 10, 2, 5, 17, 0);

        // reset during GAP, then a normal sequence
        run_seq(14'd200, 14'd2, 8, 3, 1, 0, 5);
        run_seq(14'd300, 14'd3, 5, 2, 2, 0, 0);

        // randomized sequences
        for (int i = 0; i < 25; i++) begin
            int          ln_r;
            int          pr_r;
            int          np_r;
            int          dl_r;
            int          ab_r;
            logic [13:0] st_r;
            st_r = 14'($urandom);
            ln_r = int'($urandom_range(1, 6));
            pr_r = ln_r + int'($urandom_range(0, 5));
            np_r = int'($urandom_range(1, 4));
            dl_r = int'($urandom_range(0, 6));
            ab_r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
            if ($urandom_range(0, 1) == 1) begin
                pps = 1'b1;
                tick();
                pps = 1'b0;
                check_val("rand_idle_busy", 32'(busy), 0);
            end
            repeat ($urandom_range(0, 2)) tick();
            run_seq(st_r, 14'(ln_r), pr_r, np_r, dl_r, ab_r, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
